// File: rtl/div_sched.sv
// Programmable clock divider: divided square wave plus period-end strobe,
// with ratio updates deferred to period boundaries so no runt pulse is produced.
module div_sched #(
    parameter int CNT_W     = 8,
    parameter int DEF_RATIO = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_cfg_valid,
    input  logic [CNT_W-1:0] i_cfg_ratio,
    output logic             o_cfg_ready,
    output logic             o_cfg_err,
    output logic             o_div_out,
    output logic             o_tick,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_cur_ratio
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_RATIO);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ratio;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_tick;
    logic             r_div;
    logic             r_busy;
    logic             r_ready;
    logic             r_err;

    logic [1:0]       w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_ratio_nx;
    logic [CNT_W-1:0] w_pend_nx;
    logic             w_pend_vld_nx;
    logic [CNT_W-1:0] w_low_len_nx;
    logic             w_run_nx;
    logic             w_xfer;
    logic             w_legal;
    logic             w_bnd;

    assign w_xfer  = i_cfg_valid & r_ready;
    assign w_legal = (i_cfg_ratio >= TWO);
    assign w_bnd   = (r_state != ST_STOP) && (r_cnt == r_ratio - ONE);

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_ratio_nx    = r_ratio;
        w_pend_nx     = r_pend;
        w_pend_vld_nx = r_pend_vld;
        case (r_state)
            ST_STOP: begin
                if (w_xfer && w_legal)
                    w_ratio_nx = i_cfg_ratio;
                if (i_en) begin
                    w_state_nx = ST_RUN;
                    w_cnt_nx   = '0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (w_bnd) begin
                    // A write landing on the boundary beats any pending value;
                    // pending can only exist when ready was low, so both never coincide.
                    w_cnt_nx      = '0;
                    w_pend_vld_nx = 1'b0;
                    if (w_xfer && w_legal)
                        w_ratio_nx = i_cfg_ratio;
                    else if (r_pend_vld)
                        w_ratio_nx = r_pend;
                    w_state_nx = i_en ? ST_RUN : ST_STOP;
                end else begin
                    w_cnt_nx = r_cnt + ONE;
                    if (w_xfer && w_legal) begin
                        w_pend_vld_nx = 1'b1;
                        w_pend_nx     = i_cfg_ratio;
                    end
                    w_state_nx = i_en ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                w_state_nx    = ST_STOP;
                w_cnt_nx      = '0;
                w_pend_vld_nx = 1'b0;
            end
        endcase
    end

    // Outputs are flopped from the next-state view so they line up with r_cnt.
    assign w_run_nx     = (w_state_nx != ST_STOP);
    assign w_low_len_nx = w_ratio_nx - (w_ratio_nx >> 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_STOP;
            r_cnt      <= '0;
            r_ratio    <= DEF_N;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_tick     <= 1'b0;
            r_div      <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_ratio    <= w_ratio_nx;
            r_pend     <= w_pend_nx;
            r_pend_vld <= w_pend_vld_nx;
            r_tick     <= w_run_nx && (w_cnt_nx == w_ratio_nx - ONE);
            r_div      <= w_run_nx && (w_cnt_nx >= w_low_len_nx);
            r_busy     <= w_run_nx;
            r_ready    <= !w_pend_vld_nx;
            r_err      <= w_xfer && !w_legal;
        end
    end

    assign o_cfg_ready = r_ready;
    assign o_cfg_err   = r_err;
    assign o_div_out   = r_div;
    assign o_tick      = r_tick;
    assign o_busy      = r_busy;
    assign o_cur_ratio = r_ratio;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: directed scenarios plus random traffic, each cycle
// compared against a period-level model of the divider.
module tb_div_sched;

    localparam int W   = 8;
    localparam int DEF = 8;
    localparam int VW  = 5 + W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic         cv  = 1'b0;
    logic [W-1:0] cr  = '0;
    logic         rdy, err, dout, tick, busy;
    logic [W-1:0] cur;

    always #5 clk = ~clk;

    div_sched #(.CNT_W(W), .DEF_RATIO(DEF)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_cfg_valid (cv),
        .i_cfg_ratio (cr),
        .o_cfg_ready (rdy),
        .o_cfg_err   (err),
        .o_div_out   (dout),
        .o_tick      (tick),
        .o_busy      (busy),
        .o_cur_ratio (cur)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: running flag, position in period, ratio, and a queue of at most one pending ratio.
    bit m_busy;
    int m_cnt;
    int m_n;
    int m_pend[$];
    bit m_ready;
    bit m_err;

    task automatic model_edge(input bit r, input bit e, input bit v, input int nr);
        bit xfer, ok, bnd;
        if (r) begin
            m_busy = 0; m_cnt = 0; m_n = DEF; m_pend.delete(); m_ready = 1; m_err = 0;
            return;
        end
        xfer  = v && m_ready;
        ok    = xfer && (nr >= 2);
        m_err = xfer && (nr < 2);
        bnd   = m_busy && (m_cnt == m_n - 1);
        if (!m_busy) begin
            if (ok) m_n = nr;
            if (e) begin m_busy = 1; m_cnt = 0; end
        end else if (bnd) begin
            m_cnt = 0;
            if (ok) m_n = nr;
            else if (m_pend.size() > 0) m_n = m_pend.pop_front();
            m_pend.delete();
            m_busy = e;
        end else begin
            m_cnt++;
            if (ok) m_pend.push_back(nr);
        end
        m_ready = (m_pend.size() == 0);
    endtask

    function automatic logic [VW-1:0] expv();
        logic [W-1:0] n;
        logic         d, t;
        n = W'(m_n);
        d = m_busy && (m_cnt >= m_n - m_n / 2);
        t = m_busy && (m_cnt == m_n - 1);
        expv = {m_busy, d, t, m_ready, m_err, n};
    endfunction

    function automatic logic [VW-1:0] obsv();
        obsv = {busy, dout, tick, rdy, err, cur};
    endfunction

    task automatic cyc(input bit r, input bit e, input bit v, input int nr);
        rst = r; en = e; cv = v; cr = W'(nr);
        @(posedge clk);
        model_edge(r, e, v, nr);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 5);
        n_chk++;
        if ({busy, dout, tick, rdy, err, cur} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(DEF)})
            $display("FAIL reset_state: got %h want %h", {busy, dout, tick, rdy, err, cur}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(DEF)});
        else n_pass++;
        cyc(0, 0, 0, 0);
        n_chk++;
        if (obsv() !== expv()) $display("FAIL reset_idle: got %h want %h", obsv(), expv());
        else n_pass++;
    endtask

    task automatic test_default_run();
        int ft = -1, fr = -1, highs = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc(0, 1, 0, 0);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL default_run cyc %0d: got %h want %h", k, obsv(), expv());
            else n_pass++;
            if (tick && ft < 0) ft = k;
            if (dout && fr < 0) fr = k;
            if (k <= 8 && dout) highs++;
        end
        n_chk++;
        if (ft !== 8) $display("FAIL default_first_tick: got %0d want 8", ft); else n_pass++;
        n_chk++;
        if (fr !== 5) $display("FAIL default_first_rise: got %0d want 5", fr); else n_pass++;
        n_chk++;
        if (highs !== 4) $display("FAIL default_high_len: got %0d want 4", highs); else n_pass++;
    endtask

    task automatic test_odd_from_stop();
        int ft = -1, fr = -1, highs = 0, k = 0;
        while (busy && k < 20) begin
            cyc(0, 0, 0, 0);
            k++;
            n_chk++;
            if (obsv() !== expv()) $display("FAIL odd_stopping: got %h want %h", obsv(), expv());
            else n_pass++;
        end
        n_chk++;
        if (busy !== 1'b0) $display("FAIL odd_stop_timeout: busy got %b want 0", busy); else n_pass++;
        cyc(0, 0, 1, 5);
        n_chk++;
        if (cur !== W'(5)) $display("FAIL odd_cur_ratio: got %0d want 5", cur); else n_pass++;
        for (int j = 1; j <= 20; j++) begin
            cyc(0, 1, 0, 0);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL odd_run cyc %0d: got %h want %h", j, obsv(), expv());
            else n_pass++;
            if (tick && ft < 0) ft = j;
            if (dout && fr < 0) fr = j;
            if (j <= 5 && dout) highs++;
        end
        n_chk++;
        if (ft !== 5) $display("FAIL odd_first_tick: got %0d want 5", ft); else n_pass++;
        n_chk++;
        if (fr !== 4) $display("FAIL odd_first_rise: got %0d want 4", fr); else n_pass++;
        n_chk++;
        if (highs !== 2) $display("FAIL odd_high_len: got %0d want 2", highs); else n_pass++;
    endtask

    task automatic test_mid_reconfig();
        int lows = 0, ticks = 0, highs = 0;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 3);
        for (int j = 0; j < 5; j++) begin
            if (j > 0) cyc(0, 1, 0, 0);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL mid_hold cyc %0d: got %h want %h", j, obsv(), expv());
            else n_pass++;
            if (!rdy) lows++;
        end
        n_chk++;
        if (lows !== 5) $display("FAIL mid_ready_low: got %0d want 5", lows); else n_pass++;
        cyc(0, 1, 0, 0);
        n_chk++;
        if ({rdy, cur} !== {1'b1, W'(3)}) $display("FAIL mid_new_period: got %h want %h", {rdy, cur}, {1'b1, W'(3)});
        else n_pass++;
        for (int j = 0; j < 9; j++) begin
            if (j > 0) cyc(0, 1, 0, 0);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL mid_n3 cyc %0d: got %h want %h", j, obsv(), expv());
            else n_pass++;
            if (tick) ticks++;
            if (dout) highs++;
        end
        n_chk++;
        if ({ticks, highs} !== {32'd3, 32'd3}) $display("FAIL mid_n3_shape: ticks %0d highs %0d want 3 3", ticks, highs);
        else n_pass++;
    endtask

    task automatic test_boundary_and_illegal();
        int k = 0, ticks = 0, drops = 0, errs = 0;
        while (!tick && k < 10) begin
            cyc(0, 1, 0, 0);
            k++;
        end
        n_chk++;
        if (tick !== 1'b1) $display("FAIL bnd_wait_tick: got %b want 1", tick); else n_pass++;
        cyc(0, 1, 1, 4);
        n_chk++;
        if (cur !== W'(4)) $display("FAIL bnd_cur_ratio: got %0d want 4", cur); else n_pass++;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) cyc(0, 1, 0, 0);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL bnd_run cyc %0d: got %h want %h", j, obsv(), expv());
            else n_pass++;
            if (tick) ticks++;
            if (!rdy) drops++;
        end
        n_chk++;
        if ({ticks, drops} !== {32'd2, 32'd0}) $display("FAIL bnd_shape: ticks %0d ready_drops %0d want 2 0", ticks, drops);
        else n_pass++;
        cyc(0, 1, 1, 1);
        for (int j = 0; j < 6; j++) begin
            if (j > 0) cyc(0, 1, 0, 0);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL illegal cyc %0d: got %h want %h", j, obsv(), expv());
            else n_pass++;
            if (err) errs++;
        end
        n_chk++;
        if ({errs, 24'd0, cur} !== {32'd1, 24'd0, W'(4)}) $display("FAIL illegal_err: pulses %0d ratio %0d want 1 4", errs, cur);
        else n_pass++;
    endtask

    task automatic test_drain_and_reenable();
        int tick_at = -1, gaps = 0, ticks = 0;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        for (int j = 1; j <= 6; j++) begin
            cyc(0, 0, 0, 0);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL drain cyc %0d: got %h want %h", j, obsv(), expv());
            else n_pass++;
            if (tick && tick_at < 0) tick_at = j;
        end
        n_chk++;
        if (tick_at !== 5) $display("FAIL drain_tick: got %0d want 5", tick_at); else n_pass++;
        n_chk++;
        if ({busy, dout} !== 2'b00) $display("FAIL drain_stopped: got %b want 00", {busy, dout}); else n_pass++;
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int j = 1; j <= 20; j++) begin
            cyc(0, 1, 0, 0);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL reenable cyc %0d: got %h want %h", j, obsv(), expv());
            else n_pass++;
            if (!busy) gaps++;
            if (tick) ticks++;
        end
        n_chk++;
        if ({gaps, ticks} !== {32'd0, 32'd3}) $display("FAIL reenable_shape: gaps %0d ticks %0d want 0 3", gaps, ticks);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ft = -1;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 5);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        n_chk++;
        if ({busy, rdy} !== 2'b10) $display("FAIL rstmid_pending: got %b want 10", {busy, rdy}); else n_pass++;
        cyc(1, 1, 1, 7);
        n_chk++;
        if ({busy, dout, tick, rdy, err, cur} !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(DEF)})
            $display("FAIL rstmid_state: got %h want %h", {busy, dout, tick, rdy, err, cur}, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(DEF)});
        else n_pass++;
        for (int j = 1; j <= 16; j++) begin
            cyc(0, 1, 0, 0);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL rstmid_run cyc %0d: got %h want %h", j, obsv(), expv());
            else n_pass++;
            if (tick && ft < 0) ft = j;
        end
        n_chk++;
        if (ft !== 8) $display("FAIL rstmid_first_tick: got %0d want 8", ft); else n_pass++;
    endtask

    task automatic test_random();
        bit e = 0;
        bit v;
        bit r;
        int nr;
        cyc(1, 0, 0, 0);
        for (int j = 0; j < 2000; j++) begin
            if ($urandom_range(0, 19) == 0) e = !e;
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 5) == 0);
            nr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 12));
            cyc(r, e, v, nr);
            n_chk++;
            if (obsv() !== expv()) $display("FAIL random cyc %0d: got %h want %h", j, obsv(), expv());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_odd_from_stop();
        test_mid_reconfig();
        test_boundary_and_illegal();
        test_drain_and_reenable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
